// File: rtl/regfile_dump_reader_if.sv
// ----------------------------------------------------------------------------
// regfile_dump_reader_if
//
// Purpose : groups the control, register-file read port and dump stream
//           signals of regfile_dump_reader into one bundle.
//
// Signals :
//   Start        request a dump (only honoured while the reader is idle)
//   Abort        terminate a dump in progress
//   ReadRegister index driven to the register-file read port
//   ReadData     combinational read data for ReadRegister
//   DumpValid    DumpIndex/DumpData carry a beat
//   DumpReady    consumer accepts the beat
//   DumpIndex    register index of the current beat
//   DumpData     captured register value of the current beat
//   Busy         dump in progress
//   Done         one-cycle pulse after the final beat is accepted
//
// Modports:
//   master : the dump reader itself
//   slave  : the environment (control source, register file, consumer)
// ----------------------------------------------------------------------------
interface regfile_dump_reader_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  Start;
    logic                  Abort;
    logic [ADDR_WIDTH-1:0] ReadRegister;
    logic [DATA_WIDTH-1:0] ReadData;
    logic                  DumpValid;
    logic                  DumpReady;
    logic [ADDR_WIDTH-1:0] DumpIndex;
    logic [DATA_WIDTH-1:0] DumpData;
    logic                  Busy;
    logic                  Done;

    modport master (
        input  Start,
        input  Abort,
        input  ReadData,
        input  DumpReady,
        output ReadRegister,
        output DumpValid,
        output DumpIndex,
        output DumpData,
        output Busy,
        output Done
    );

    modport slave (
        output Start,
        output Abort,
        output ReadData,
        output DumpReady,
        input  ReadRegister,
        input  DumpValid,
        input  DumpIndex,
        input  DumpData,
        input  Busy,
        input  Done
    );
endinterface

// File: rtl/regfile_dump_reader.sv
// ----------------------------------------------------------------------------
// regfile_dump_reader
//
// Purpose : debug client of the processor register file. On each Start it
//           reads x0..LAST_REG through a dedicated read port, one register at
//           a time, and presents every value tagged with its index on a
//           valid/ready stream toward the debug path. It never writes the
//           register file. LAST_REG must not exceed 2**ADDR_WIDTH-1.
//
// Ports   :
//   CLK          clock, all state changes on the rising edge
//   RESET        asynchronous, active-high reset
//   bus          regfile_dump_reader_if.master (control, read port, stream)
//   dbg_state_o  current FSM state (IDLE=0, READ=1, PRESENT=2, DONE=3)
//
// Stream handshake: a beat transfers at a rising edge where DumpValid and
// DumpReady are both high and Abort is low. Once DumpValid rises, DumpIndex
// and DumpData stay constant until that transfer, an Abort, or RESET.
// DumpValid is a pure state decode and never looks at DumpReady.
//
// Each register costs two cycles: READ drives the index and captures the
// combinational read data at its closing edge; PRESENT offers the captured
// value. Because capture happens at the closing edge of READ, a register-file
// write landing on that same edge is not seen (snapshot of the old value).
// ----------------------------------------------------------------------------
module regfile_dump_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int LAST_REG   = 31
) (
    input  logic                          CLK,
    input  logic                          RESET,
    regfile_dump_reader_if.master         bus,
    output logic [1:0]                    dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_READ    = 2'd1,
        S_PRESENT = 2'd2,
        S_DONE    = 2'd3
    } state_e;

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(LAST_REG);
    localparam logic [ADDR_WIDTH-1:0] IDX_ONE  = ADDR_WIDTH'(1);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;       // register currently being walked
    logic [ADDR_WIDTH-1:0] index_q, index_d;   // index tag of the presented beat
    logic [DATA_WIDTH-1:0] data_q, data_d;     // captured register value

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            index_q <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            index_q <= index_d;
            data_q  <= data_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        index_d = index_q;
        data_d  = data_q;

        case (state_q)
            S_IDLE: begin
                if (bus.Start) begin
                    idx_d   = '0;
                    state_d = S_READ;
                end
            end

            S_READ: begin
                if (bus.Abort) begin
                    state_d = S_IDLE;
                end else begin
                    data_d  = bus.ReadData;
                    index_d = idx_q;
                    state_d = S_PRESENT;
                end
            end

            S_PRESENT: begin
                // Abort wins over a simultaneous handshake: the beat is
                // treated as not accepted.
                if (bus.Abort) begin
                    state_d = S_IDLE;
                end else if (bus.DumpReady) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        // No wrap possible: the last index leaves via DONE.
                        idx_d   = idx_q + IDX_ONE;
                        state_d = S_READ;
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs: all decoded from registered state only
    // ------------------------------------------------------------------
    assign bus.ReadRegister = (state_q == S_READ) ? idx_q : '0;
    assign bus.DumpValid    = (state_q == S_PRESENT);
    assign bus.Busy         = (state_q == S_READ) || (state_q == S_PRESENT);
    assign bus.Done         = (state_q == S_DONE);
    assign bus.DumpIndex    = index_q;
    assign bus.DumpData     = data_q;
    assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_regfile_dump_reader.sv
module tb_regfile_dump_reader;

    localparam int DW   = 32;
    localparam int AW   = 5;
    localparam int NREG = 32;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic CLK   = 1'b0;
    logic RESET = 1'b1;
    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // ------------------------------------------------------------------
    // DUTs: full-width dump and a LAST_REG=3 build
    // ------------------------------------------------------------------
    regfile_dump_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) a_if ();
    regfile_dump_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) b_if ();
    logic [1:0] a_state;
    logic [1:0] b_state;

    regfile_dump_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LAST_REG(31)) u_dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .bus         (a_if.master),
        .dbg_state_o (a_state)
    );

    regfile_dump_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LAST_REG(3)) u_dut_small (
        .CLK         (CLK),
        .RESET       (RESET),
        .bus         (b_if.master),
        .dbg_state_o (b_state)
    );

    // ------------------------------------------------------------------
    // Register file model (shared by both readers)
    // ------------------------------------------------------------------
    logic [DW-1:0] rf [NREG];
    logic          rf_init;
    logic          rf_we;
    logic [AW-1:0] rf_wa;
    logic [DW-1:0] rf_wd;

    always @(posedge CLK) begin
        if (rf_init) begin
            for (int i = 0; i < NREG; i++) rf[i] <= 32'hA500_0000 + DW'(i);
        end else if (rf_we) begin
            rf[rf_wa] <= rf_wd;
        end
    end

    assign a_if.ReadData = rf[a_if.ReadRegister];
    assign b_if.ReadData = rf[b_if.ReadRegister];

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Scoreboard for the full reader: expected beats {index, data}
    // ------------------------------------------------------------------
    logic [AW+DW-1:0] exp_q [$];
    int  a_hs = 0;
    int  a_done = 0;
    int  a_last_hs_edge = 0;
    int  hs_base = 0;
    int  start_edge = 0;
    bit  timing_on = 1'b0;
    logic          hold_q = 1'b0;
    logic [AW-1:0] hold_idx = '0;
    logic [DW-1:0] hold_data = '0;

    always @(posedge CLK) begin
        logic [AW+DW-1:0] e;
        if (RESET) begin
            hold_q <= 1'b0;
        end else begin
            if (hold_q) begin
                check("hold_valid", 64'(a_if.DumpValid), 64'd1);
                check("hold_index", 64'(a_if.DumpIndex), 64'(hold_idx));
                check("hold_data",  64'(a_if.DumpData),  64'(hold_data));
            end
            hold_q    <= a_if.DumpValid && !a_if.DumpReady && !a_if.Abort;
            hold_idx  <= a_if.DumpIndex;
            hold_data <= a_if.DumpData;

            if (a_if.DumpValid && a_if.DumpReady && !a_if.Abort) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 64'(a_if.DumpIndex), 64'hFFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_index", 64'(a_if.DumpIndex), 64'(e[AW+DW-1:DW]));
                    check("beat_data",  64'(a_if.DumpData),  64'(e[DW-1:0]));
                end
                if (timing_on)
                    check("beat_edge", 64'(cyc + 1), 64'(start_edge + 2 + 2 * (a_hs - hs_base)));
                a_hs           <= a_hs + 1;
                a_last_hs_edge <= cyc + 1;
            end

            if (a_if.Done) begin
                check("done_edge",       64'(cyc + 1), 64'(a_last_hs_edge + 1));
                check("done_exp_empty",  64'(exp_q.size()), 64'd0);
                check("done_busy_low",   64'(a_if.Busy), 64'd0);
                check("done_valid_low",  64'(a_if.DumpValid), 64'd0);
                a_done <= a_done + 1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Monitor for the LAST_REG=3 reader: beat k must be {k, rf[k]}
    // ------------------------------------------------------------------
    int b_hs = 0;
    int b_done = 0;

    always @(posedge CLK) begin
        if (!RESET) begin
            if (b_if.DumpValid && b_if.DumpReady && !b_if.Abort) begin
                check("b_beat_index", 64'(b_if.DumpIndex), 64'(b_hs));
                check("b_beat_data",  64'(b_if.DumpData),  64'(rf[b_hs % NREG]));
                b_hs <= b_hs + 1;
            end
            if (b_if.Done) b_done <= b_done + 1;
        end
    end

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic snapshot_a();
        exp_q.delete();
        for (int i = 0; i < NREG; i++) exp_q.push_back({AW'(i), rf[i]});
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_readreg"}, 64'(a_if.ReadRegister), 64'd0);
        check({tag, "_valid"},   64'(a_if.DumpValid),    64'd0);
        check({tag, "_index"},   64'(a_if.DumpIndex),    64'd0);
        check({tag, "_data"},    64'(a_if.DumpData),     64'd0);
        check({tag, "_busy"},    64'(a_if.Busy),         64'd0);
        check({tag, "_done"},    64'(a_if.Done),         64'd0);
    endtask

    // One dump on the full reader. abort_at/reset_at/write_at < 0 disable
    // the corresponding disturbance.
    task automatic run_a(input bit rnd, input int abort_at, input int reset_at,
                         input int write_at);
        int  hs0;
        int  done0;
        int  exp_beats;
        bit  ended;
        hs0   = a_hs;
        done0 = a_done;
        ended = 1'b0;
        exp_beats = (abort_at >= 0) ? abort_at : (reset_at >= 0) ? reset_at : NREG;

        @(negedge CLK);
        snapshot_a();
        timing_on      = !rnd && (abort_at < 0) && (reset_at < 0);
        hs_base        = a_hs;
        start_edge     = cyc + 1;
        a_if.Start     = 1'b1;
        a_if.DumpReady = rnd ? 1'($urandom_range(0, 1)) : 1'b1;

        for (int n = 0; n < 400; n++) begin
            @(negedge CLK);
            a_if.Start = 1'b0;
            a_if.Abort = 1'b0;
            rf_we      = 1'b0;
            if (a_done != done0) begin
                ended = 1'b1;
                break;
            end
            a_if.DumpReady = rnd ? 1'($urandom_range(0, 1)) : 1'b1;

            if (write_at >= 0 && a_if.Busy && !a_if.DumpValid &&
                a_if.ReadRegister == AW'(write_at)) begin
                rf_we = 1'b1;
                rf_wa = AW'(write_at);
                rf_wd = 32'hDEAD_BEEF;
            end

            if (abort_at >= 0 && a_if.DumpValid && a_if.DumpIndex == AW'(abort_at)) begin
                a_if.Abort     = 1'b1;
                a_if.DumpReady = 1'b1;
                @(negedge CLK);
                a_if.Abort = 1'b0;
                check("abort_valid_low", 64'(a_if.DumpValid), 64'd0);
                check("abort_busy_low",  64'(a_if.Busy),      64'd0);
                exp_q.delete();
                ended = 1'b1;
                break;
            end

            if (reset_at >= 0 && a_if.DumpValid && a_if.DumpIndex == AW'(reset_at)) begin
                #2;
                RESET = 1'b1;
                #1;
                check_idle_outputs("midreset");
                @(negedge CLK);
                RESET = 1'b0;
                exp_q.delete();
                ended = 1'b1;
                break;
            end
        end

        if (!ended) check("dump_timeout", 64'd1, 64'd0);
        timing_on = 1'b0;
        repeat (3) @(negedge CLK);
        check("beats_accepted", 64'(a_hs - hs0), 64'(exp_beats));
        check("done_pulses",    64'(a_done - done0),
              64'((abort_at < 0 && reset_at < 0) ? 1 : 0));
        check("after_busy_low", 64'(a_if.Busy), 64'd0);
        check("after_done_low", 64'(a_if.Done), 64'd0);
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        a_if.Start = 1'b0; a_if.Abort = 1'b0; a_if.DumpReady = 1'b0;
        b_if.Start = 1'b0; b_if.Abort = 1'b0; b_if.DumpReady = 1'b1;
        rf_init = 1'b1; rf_we = 1'b0; rf_wa = '0; rf_wd = '0;
        RESET = 1'b1;

        repeat (2) @(negedge CLK);
        rf_init = 1'b0;
        check_idle_outputs("reset");
        RESET = 1'b0;
        @(negedge CLK);

        // Back-to-back dump with the consumer always ready
        run_a(1'b0, -1, -1, -1);
        // Random back-pressure
        run_a(1'b1, -1, -1, -1);
        run_a(1'b1, -1, -1, -1);
        // Write landing on the capture edge of x5, then a rerun
        run_a(1'b1, -1, -1, 5);
        run_a(1'b0, -1, -1, -1);
        // Abort together with ready at index 10, then a clean restart
        run_a(1'b0, 10, -1, -1);
        run_a(1'b0, -1, -1, -1);
        // Asynchronous reset at index 17, then a clean restart
        run_a(1'b0, -1, 17, -1);
        run_a(1'b1, -1, -1, -1);

        // LAST_REG=3 build with a second Start while it is busy
        @(negedge CLK);
        b_if.Start = 1'b1;
        @(negedge CLK);
        b_if.Start = 1'b0;
        repeat (2) @(negedge CLK);
        check("b_busy_at_restart", 64'(b_if.Busy), 64'd1);
        b_if.Start = 1'b1;
        @(negedge CLK);
        b_if.Start = 1'b0;
        repeat (30) @(negedge CLK);
        check("b_beats",     64'(b_hs),      64'd4);
        check("b_done",      64'(b_done),    64'd1);
        check("b_busy_low",  64'(b_if.Busy), 64'd0);
        check("b_valid_low", 64'(b_if.DumpValid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
